ps2_mouse_cursor_tracker: RTL and testbench
===========================================

// Module: ps2_mouse_cursor_tracker
// PURPOSE
//  Consumer stage for the PS/2 mouse receiver. Takes each decoded packet
//  (buttons, 9-bit signed X/Y increments) over the data_ready/read handshake.
//  Accumulates an absolute cursor position clamped to a screen window.
//  Publishes registered cursor, button state and button-press strobes to the
//  display/UI logic.
// PARAMETERS
//  POS_BITS  10   width of cursor_x/cursor_y
//  X_MAX     639  largest legal cursor_x (smallest is 0)
//  Y_MAX     479  largest legal cursor_y (smallest is 0)
//  X_INIT    320  cursor_x after reset/recenter
//  Y_INIT    240  cursor_y after reset/recenter
//  INVERT_Y  1    1: screen Y grows downward (pos - dy); 0: pos + dy
// PORTS
//  clk            in   1         system clock
//  reset          in   1         synchronous, active-high reset
//  data_ready     in   1         upstream packet valid, level, held until read
//  read           out  1         one-cycle acknowledge to upstream
//  left_button    in   1         upstream packet fields; stable while data_ready=1
//  right_button   in   1
//  middle_button  in   1
//  x_increment    in   9         two's complement dx
//  y_increment    in   9         two's complement dy (mouse-up positive)
//  recenter       in   1         level; forces cursor to X_INIT/Y_INIT
//  cursor_x       out  POS_BITS  absolute X, registered
//  cursor_y       out  POS_BITS  absolute Y, registered
//  buttons        out  3         {middle,right,left}, registered
//  btn_press      out  3         one-cycle pulse per button on 0->1 transition
//  update         out  1         one-cycle pulse when outputs take a new packet
// BEHAVIOUR
//  Single clock domain. reset is synchronous and active-high.
//  Reset values: cursor_x=X_INIT, cursor_y=Y_INIT, buttons=0, btn_press=0,
//   update=0, read=0, FSM=S_IDLE, discard flag=0.
//  FSM states: S_IDLE -> S_ACK -> S_CALC_X -> S_CALC_Y -> S_COMMIT -> S_IDLE.
//  S_IDLE: when data_ready=1, capture the 3 buttons, x_increment and
//   y_increment into working regs, then go to S_ACK.
//  S_ACK: read=1 (registered, this cycle only). Go to S_CALC_X.
//   Upstream drops data_ready the cycle after it samples read, so S_IDLE is
//   never re-entered on the same packet.
//  S_CALC_X: nx = cursor_x + sext(dx), computed at POS_BITS+2 signed.
//   nx<0 -> 0; nx>X_MAX -> X_MAX; otherwise nx.
//  S_CALC_Y: ny = cursor_y - sext(dy) if INVERT_Y=1, else cursor_y + sext(dy).
//   Same clamp, using Y_MAX.
//  S_COMMIT: at the closing edge, load cursor_x/y from the clamped values and
//   buttons from the captured buttons. Set btn_press = captured & ~buttons(old).
//   Set update=1. Return to S_IDLE.
//  Latency: data_ready first sampled high in cycle N gives read high in N+1.
//   New outputs and update/btn_press pulses appear in N+5.
//   Throughput is one packet per 5 cycles.
//  update and btn_press are high for exactly one cycle, otherwise 0.
//  Position is never outside [0,MAX]. Clamping saturates; it never wraps.
//   Extreme inputs -256 and +255 are legal.
//  recenter=1 in any cycle: cursor_x/y <= X_INIT/Y_INIT at that edge.
//   If recenter is seen anywhere from S_ACK through S_COMMIT, the in-flight
//   packet's motion is discarded. That packet's buttons, btn_press and update
//   still commit.
//   recenter in S_COMMIT: position result is INIT; update=1.
//  The FSM ignores data_ready outside S_IDLE. read never asserts outside S_ACK.
//  Reset mid-packet: all state returns to reset values, no read is issued.
//   A still-pending upstream packet is taken normally after reset deasserts.
//  Working regs are not exposed. Outputs change only in the S_COMMIT edge,
//   on recenter, or on reset.
// TESTING
//  T1 reset, then packet dx=+5, dy=+3, left=1 -> read pulse in N+1; in N+5:
//     cursor=(325,237), buttons=3'b001, btn_press=3'b001, update=1 for 1 cycle.
//  T2 from (320,240), dx=-256 (9'h100) x3 packets -> cursor_x 64, then 0, then
//     0. dx=+255 x2 from 600 -> 639.
//  T3 INVERT_Y=0 build: dy=+10 from Y_INIT -> cursor_y=250; dy=-300 is
//     unrepresentable, so dy=-256 from 100 -> 0.
//  T4 data_ready held high across 3 back-to-back packets -> exactly 3 read
//     pulses, each 5 cycles apart, 3 update pulses, no packet lost or repeated.
//  T5 recenter asserted in S_CALC_X of packet dx=+50, left=1 -> cursor=(320,240)
//     with update=1 and buttons=3'b001. Recenter while idle -> INIT, no update.
//  T6 reset asserted in S_CALC_Y -> outputs return to reset values next cycle,
//     read stays 0. Pending packet is consumed once after reset deasserts.

Source files
------------

// File: rtl/ps2_mouse_cursor_tracker_if.sv
// Packet handshake between the PS/2 mouse receiver (master) and the
// cursor tracker (slave): decoded packet fields plus data_ready/read.
interface ps2_mouse_cursor_tracker_if;
  logic       data_ready;
  logic       read;
  logic       left_button;
  logic       right_button;
  logic       middle_button;
  logic [8:0] x_increment;
  logic [8:0] y_increment;

  modport master (
    output data_ready, left_button, right_button, middle_button,
           x_increment, y_increment,
    input  read
  );

  modport slave (
    input  data_ready, left_button, right_button, middle_button,
           x_increment, y_increment,
    output read
  );
endinterface

// File: rtl/ps2_mouse_cursor_tracker.sv
// Cursor tracker: consumes PS/2 mouse packets, accumulates a clamped absolute
// cursor position and publishes registered cursor/button state with one-cycle
// update and button-press strobes. Five-cycle packet sequence per packet.
module ps2_mouse_cursor_tracker #(
  parameter int POS_BITS = 10,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240,
  parameter int INVERT_Y = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  ps2_mouse_cursor_tracker_if.slave   pkt,
  input  logic                        recenter,
  output logic [POS_BITS-1:0]         cursor_x,
  output logic [POS_BITS-1:0]         cursor_y,
  output logic [2:0]                  buttons,
  output logic [2:0]                  btn_press,
  output logic                        update
);

  localparam int W = POS_BITS + 2;
  localparam logic signed [W-1:0]     C_XMAX  = W'(X_MAX);
  localparam logic signed [W-1:0]     C_YMAX  = W'(Y_MAX);
  localparam logic [POS_BITS-1:0]     C_XINIT = POS_BITS'(X_INIT);
  localparam logic [POS_BITS-1:0]     C_YINIT = POS_BITS'(Y_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_CALC_X,
    S_CALC_Y,
    S_COMMIT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [2:0]           r_btn;
  logic [8:0]           r_dx;
  logic [8:0]           r_dy;
  logic [POS_BITS-1:0]  r_nx;
  logic [POS_BITS-1:0]  r_ny;
  logic                 r_discard;
  logic                 r_read;
  logic [POS_BITS-1:0]  r_cursor_x;
  logic [POS_BITS-1:0]  r_cursor_y;
  logic [2:0]           r_buttons;
  logic [2:0]           r_btn_press;
  logic                 r_update;

  logic signed [W-1:0]  w_dx_ext;
  logic signed [W-1:0]  w_dy_ext;
  logic signed [W-1:0]  w_cur_x;
  logic signed [W-1:0]  w_cur_y;
  logic signed [W-1:0]  w_sum_x;
  logic signed [W-1:0]  w_sum_y;

  // Saturate a signed candidate position into [0, vmax].
  function automatic logic [POS_BITS-1:0] f_clamp(
    input logic signed [W-1:0] v,
    input logic signed [W-1:0] vmax
  );
    logic [POS_BITS-1:0] res;
    if (v[W-1])
      res = '0;
    else if (v > vmax)
      res = vmax[POS_BITS-1:0];
    else
      res = v[POS_BITS-1:0];
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic: fixed walk through the packet sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (pkt.data_ready) w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = S_CALC_X;
      S_CALC_X: w_state_nxt = S_CALC_Y;
      S_CALC_Y: w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Sign-extended candidate positions at POS_BITS+2 bits.
  always_comb begin
    w_dx_ext = {{(W-9){r_dx[8]}}, r_dx};
    w_dy_ext = {{(W-9){r_dy[8]}}, r_dy};
    w_cur_x  = {2'b00, r_cursor_x};
    w_cur_y  = {2'b00, r_cursor_y};
    w_sum_x  = w_cur_x + w_dx_ext;
    w_sum_y  = (INVERT_Y != 0) ? (w_cur_y - w_dy_ext) : (w_cur_y + w_dy_ext);
  end

  // Datapath: capture, clamp, commit, plus recenter override.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn       <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_nx        <= '0;
      r_ny        <= '0;
      r_discard   <= 1'b0;
      r_read      <= 1'b0;
      r_cursor_x  <= C_XINIT;
      r_cursor_y  <= C_YINIT;
      r_buttons   <= '0;
      r_btn_press <= '0;
      r_update    <= 1'b0;
    end else begin
      r_read      <= (w_state_nxt == S_ACK);
      r_update    <= 1'b0;
      r_btn_press <= '0;
      case (r_state)
        S_IDLE: begin
          if (pkt.data_ready) begin
            r_btn <= {pkt.middle_button, pkt.right_button, pkt.left_button};
            r_dx  <= pkt.x_increment;
            r_dy  <= pkt.y_increment;
          end
        end
        S_CALC_X: r_nx <= f_clamp(w_sum_x, C_XMAX);
        S_CALC_Y: r_ny <= f_clamp(w_sum_y, C_YMAX);
        S_COMMIT: begin
          if (r_discard || recenter) begin
            r_cursor_x <= C_XINIT;
            r_cursor_y <= C_YINIT;
          end else begin
            r_cursor_x <= r_nx;
            r_cursor_y <= r_ny;
          end
          r_buttons   <= r_btn;
          r_btn_press <= r_btn & ~r_buttons;
          r_update    <= 1'b1;
          r_discard   <= 1'b0;
        end
        default: ;
      endcase
      // Recenter wins over any datapath write; mid-packet it also poisons the
      // in-flight motion (COMMIT already lands on INIT via the branch above).
      if (recenter) begin
        r_cursor_x <= C_XINIT;
        r_cursor_y <= C_YINIT;
        if (r_state != S_IDLE && r_state != S_COMMIT)
          r_discard <= 1'b1;
      end
    end
  end

  assign pkt.read  = r_read;
  assign cursor_x  = r_cursor_x;
  assign cursor_y  = r_cursor_y;
  assign buttons   = r_buttons;
  assign btn_press = r_btn_press;
  assign update    = r_update;

endmodule

// File: tb/tb_ps2_mouse_cursor_tracker.sv
// Scoreboard bench for ps2_mouse_cursor_tracker: stimulus pushes hand-computed
// expected commits; per-DUT monitors pop and compare on every update pulse.
module tb_ps2_mouse_cursor_tracker;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] b;
    logic [2:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic rc_a, rc_b;
  logic [9:0] cx_a, cy_a, cx_b, cy_b;
  logic [2:0] bt_a, bp_a, bt_b, bp_b;
  logic       up_a, up_b;

  int n_vec = 0;
  int n_err = 0;
  int rda_cnt = 0;
  exp_t qa[$];
  exp_t qb[$];

  ps2_mouse_cursor_tracker_if ifa();
  ps2_mouse_cursor_tracker_if ifb();

  ps2_mouse_cursor_tracker dut_a (
    .clk(clk), .reset(reset), .pkt(ifa.slave), .recenter(rc_a),
    .cursor_x(cx_a), .cursor_y(cy_a), .buttons(bt_a), .btn_press(bp_a),
    .update(up_a)
  );

  ps2_mouse_cursor_tracker #(.INVERT_Y(0)) dut_b (
    .clk(clk), .reset(reset), .pkt(ifb.slave), .recenter(rc_b),
    .cursor_x(cx_b), .cursor_y(cy_b), .buttons(bt_b), .btn_press(bp_b),
    .update(up_b)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1);
  end

  // Monitor for DUT A: every update pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ifa.read) rda_cnt++;
    if (up_a) begin : mon_a
      exp_t e, act;
      act = {cx_a, cy_a, bt_a, bp_a};
      n_vec++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL A_unexpected_update act=(%0d,%0d,b%b,p%b) req=none", cx_a, cy_a, bt_a, bp_a);
      end else begin
        e = qa.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL A_commit act=(%0d,%0d,b%b,p%b) req=(%0d,%0d,b%b,p%b)",
                   cx_a, cy_a, bt_a, bp_a, e.x, e.y, e.b, e.p);
        end
      end
    end
  end

  // Monitor for DUT B (INVERT_Y=0 build).
  always @(negedge clk) begin
    if (up_b) begin : mon_b
      exp_t e, act;
      act = {cx_b, cy_b, bt_b, bp_b};
      n_vec++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL B_unexpected_update act=(%0d,%0d,b%b,p%b) req=none", cx_b, cy_b, bt_b, bp_b);
      end else begin
        e = qb.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL B_commit act=(%0d,%0d,b%b,p%b) req=(%0d,%0d,b%b,p%b)",
                   cx_b, cy_b, bt_b, bp_b, e.x, e.y, e.b, e.p);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic drive(input bit sel, input logic [2:0] btn, input logic [8:0] dx,
                       input logic [8:0] dy, input logic dr);
    if (sel) begin
      {ifb.middle_button, ifb.right_button, ifb.left_button} = btn;
      ifb.x_increment = dx; ifb.y_increment = dy; ifb.data_ready = dr;
    end else begin
      {ifa.middle_button, ifa.right_button, ifa.left_button} = btn;
      ifa.x_increment = dx; ifa.y_increment = dy; ifa.data_ready = dr;
    end
  endtask

  function automatic logic rd(input bit sel);
    return sel ? ifb.read : ifa.read;
  endfunction

  function automatic logic upd(input bit sel);
    return sel ? up_b : up_a;
  endfunction

  // One packet through the handshake; optional latency checks and a recenter
  // pulse placed in the S_CALC_X cycle.
  task automatic send(input bit sel, input logic [2:0] btn, input logic [8:0] dx,
                      input logic [8:0] dy, input exp_t e, input bit chk_lat,
                      input bit rc);
    int n;
    if (sel) qb.push_back(e); else qa.push_back(e);
    drive(sel, btn, dx, dy, 1'b1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rd(sel) && n < 20);
    if (!rd(sel)) begin
      chk("read_timeout", 0, 1);
      drive(sel, btn, dx, dy, 1'b0);
      return;
    end
    if (chk_lat) chk("read_latency", n, 1);
    @(posedge clk); #1;
    drive(sel, btn, dx, dy, 1'b0);
    if (rc) rc_a = 1'b1;
    @(posedge clk); #1;
    rc_a = 1'b0;
    n = 2;
    while (!upd(sel) && n < 20) begin @(posedge clk); #1; n++; end
    if (!upd(sel)) chk("update_timeout", 0, 1);
    else if (chk_lat) chk("update_latency", n, 4);
  endtask

  logic [2:0] t4_b  [3] = '{3'b001, 3'b011, 3'b000};
  logic [8:0] t4_dx [3] = '{9'h19C, 9'h1D9, 9'h000};
  logic [8:0] t4_dy [3] = '{9'h064, 9'h1FF, 9'h000};

  initial begin
    int k, c0;
    int rcyc [3];
    bit adv;
    reset = 1'b1; rc_a = 1'b0; rc_b = 1'b0;
    drive(0, 3'b000, 9'h000, 9'h000, 1'b0);
    drive(1, 3'b000, 9'h000, 9'h000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cursor_x", cx_a, 320);
    chk("rst_cursor_y", cy_a, 240);
    chk("rst_buttons", bt_a, 0);
    chk("rst_btn_press", bp_a, 0);
    chk("rst_update", up_a, 0);
    chk("rst_read", ifa.read, 0);
    reset = 1'b0;

    // T1: basic packet with latency checks
    send(0, 3'b001, 9'h005, 9'h003, '{325, 237, 3'b001, 3'b001}, 1, 0);
    @(posedge clk); #1;
    chk("update_one_cycle", up_a, 0);
    chk("btn_press_one_cycle", bp_a, 0);

    // Recenter while idle: INIT, no update
    rc_a = 1'b1;
    @(posedge clk); #1;
    rc_a = 1'b0;
    chk("idle_rc_x", cx_a, 320);
    chk("idle_rc_y", cy_a, 240);
    chk("idle_rc_update", up_a, 0);
    chk("idle_rc_buttons", bt_a, 1);

    // T2: X saturation at both ends, Y saturation at both ends
    send(0, 3'b000, 9'h100, 9'h000, '{64,  240, 3'b000, 3'b000}, 0, 0);
    send(0, 3'b000, 9'h100, 9'h000, '{0,   240, 3'b000, 3'b000}, 0, 0);
    send(0, 3'b000, 9'h100, 9'h000, '{0,   240, 3'b000, 3'b000}, 0, 0);
    send(0, 3'b010, 9'h0FF, 9'h000, '{255, 240, 3'b010, 3'b010}, 0, 0);
    send(0, 3'b110, 9'h0FF, 9'h000, '{510, 240, 3'b110, 3'b100}, 0, 0);
    send(0, 3'b101, 9'h05A, 9'h000, '{600, 240, 3'b101, 3'b001}, 0, 0);
    send(0, 3'b101, 9'h0FF, 9'h000, '{639, 240, 3'b101, 3'b000}, 0, 0);
    send(0, 3'b000, 9'h0FF, 9'h000, '{639, 240, 3'b000, 3'b000}, 0, 0);
    send(0, 3'b000, 9'h000, 9'h0FF, '{639, 0,   3'b000, 3'b000}, 0, 0);
    send(0, 3'b000, 9'h000, 9'h100, '{639, 256, 3'b000, 3'b000}, 0, 0);
    send(0, 3'b000, 9'h000, 9'h100, '{639, 479, 3'b000, 3'b000}, 0, 0);

    // T4: data_ready held high across three back-to-back packets
    qa.push_back('{539, 379, 3'b001, 3'b001});
    qa.push_back('{500, 380, 3'b011, 3'b010});
    qa.push_back('{500, 380, 3'b000, 3'b000});
    k = 0; adv = 1'b0;
    drive(0, t4_b[0], t4_dx[0], t4_dy[0], 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ifa.read) begin
        if (k < 3) rcyc[k] = c;
        k++;
        adv = 1'b1;
      end else if (adv) begin
        adv = 1'b0;
        if (k < 3) drive(0, t4_b[k], t4_dx[k], t4_dy[k], 1'b1);
        else ifa.data_ready = 1'b0;
      end
    end
    ifa.data_ready = 1'b0;
    chk("b2b_read_count", k, 3);
    if (k >= 3) begin
      chk("b2b_gap1", rcyc[1] - rcyc[0], 5);
      chk("b2b_gap2", rcyc[2] - rcyc[1], 5);
    end
    chk("b2b_all_committed", qa.size(), 0);

    // T5: recenter during S_CALC_X discards motion, keeps buttons/update
    send(0, 3'b001, 9'h032, 9'h000, '{320, 240, 3'b001, 3'b001}, 0, 1);

    // T6: reset in S_CALC_Y, pending packet taken once afterwards
    drive(0, 3'b010, 9'h00A, 9'h00A, 1'b1);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!ifa.read && k < 20);
    chk("t6_read_seen", ifa.read, 1);
    @(posedge clk); #1;          // S_CALC_X
    @(posedge clk); #1;          // S_CALC_Y
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_x", cx_a, 320);
    chk("t6_rst_y", cy_a, 240);
    chk("t6_rst_buttons", bt_a, 0);
    chk("t6_rst_read", ifa.read, 0);
    reset = 1'b0;
    c0 = rda_cnt;
    send(0, 3'b010, 9'h00A, 9'h00A, '{330, 230, 3'b010, 3'b010}, 1, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_single_read", rda_cnt - c0, 1);
    chk("t6_queue_empty", qa.size(), 0);

    // T3: non-inverted Y build
    send(1, 3'b000, 9'h000, 9'h00A, '{320, 250, 3'b000, 3'b000}, 0, 0);
    send(1, 3'b000, 9'h000, 9'h16A, '{320, 100, 3'b000, 3'b000}, 0, 0);
    send(1, 3'b000, 9'h000, 9'h100, '{320, 0,   3'b000, 3'b000}, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b_queue_empty", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
